imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. It takes a full instruction word plus a format select, and produces the sign- or zero-extended immediate for every RV32I/RV64I format (S, I, B, U, J, shift-amount, CSR zimm). The result sits behind a one-stage valid/ready pipeline register with flush. It sits between the instruction-fetch/decode boundary and the ID/EX register, carrying a sideband tag so downstream logic can match immediates to instructions.

## Interface
- `XLEN`, 32 — datapath width; legal values 32 or 64.
- `TAG_W`, 8 — width of the sideband tag passed through unchanged.
- `CNT_W`, 16 — width of the illegal-select counter.
- `clk`  in  1  — clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — input beat valid.
- `in_ready`  out  1  — block can accept a beat this cycle.
- `in_instr`  in  32  — raw instruction word.
- `in_sel`  in  3  — format select: 000 S, 001 I, 010 B, 011 U, 100 J, 101 shamt, 110 zimm, 111 reserved.
- `in_tag`  in  TAG_W  — sideband tag.
- `flush`  in  1  — synchronous pipeline kill.
- `out_valid`  out  1  — output beat valid.
- `out_ready`  in  1  — consumer accepts the output beat.
- `out_imm`  out  XLEN  — generated immediate.
- `out_tag`  out  TAG_W  — tag of the output beat.
- `out_err`  out  1  — the beat used reserved select 111.
- `err_cnt`  out  CNT_W  — saturating count of accepted beats with `in_sel`=111.

## Operation
Immediate formats, with bits of `in_instr` as `i`:
- **S:** {i[31:25], i[11:7]}, sign-extended from bit 11.
- **I:** i[31:20], sign-extended from bit 11.
- **B:** {i[31], i[7], i[30:25], i[11:8], 1'b0}, sign-extended from bit 12.
- **U:** {i[31:12], 12'b0}; when XLEN=64, sign-extended from bit 31.
- **J:** {i[31], i[19:12], i[20], i[30:21], 1'b0}, sign-extended from bit 20.
- **shamt:** zero-extended i[24:20] when XLEN=32; zero-extended i[25:20] when XLEN=64.
- **zimm:** zero-extended i[19:15].
- **Reserved (111):** `out_imm`=0 and `out_err`=1. `err_cnt` increments by 1 and saturates at all-ones.

Handshake and flush:
- A beat is accepted on an edge where `in_valid` && `in_ready` && !`flush`.
- An output beat retires on an edge where `out_valid` && `out_ready`.
- `flush` clears every valid bit on the next edge and discards any same-cycle input.
- A beat accepted under `flush` does not exist, so it does not touch `err_cnt`.
- While `out_valid` && !`out_ready`, `out_imm`, `out_tag` and `out_err` hold stable.
- `in_instr`, `in_sel` and `in_tag` are don't-care when `in_valid`=0.

## Timing
- **Reset:** `out_valid`=0, `out_imm`=0, `out_tag`=0, `out_err`=0, `err_cnt`=0; `in_ready`=1 once `rst_n` deasserts.
- **Reset mid-operation:** asserting `rst_n` low drops all held beats immediately (asynchronous).
- **Latency:** a beat accepted at edge N is presented with `out_valid`=1 from edge N onward.
- **Throughput:** one beat per cycle while `out_ready`=1.
- **Simultaneous retire and accept** (one edge): the output register is replaced with no bubble cycle.
- **Flush vs. accept:** `flush` has priority over both retire and accept.
- **Select values:** `in_sel` is registered with the beat; it is never decoded combinationally to the output.

## Configuration
- **Macro:** `IMM_GEN_SKID_EN`
- **Defined:** adds a one-entry skid buffer behind the output register, and `in_ready` becomes a pure register output equal to !skid_full.
  - A beat arriving while the output stalls goes into the skid entry.
  - On retire, the skid entry moves to the output the same edge.
  - Order is strictly preserved.
  - `flush` clears both entries.
- **Undefined:** no skid entry; `in_ready` = !`out_valid` || `out_ready` (combinational from `out_ready`).

## Test plan
- **I-format:** reset, then `in_instr`=0xFFF00093, `in_sel`=001, `in_tag`=0x5A -> next cycle `out_valid`=1, `out_imm`=0xFFFFFFFF, `out_tag`=0x5A, `out_err`=0.
- **S/B/U/J back-to-back** with `out_ready`=1:
  - 0xFE20AE23/000 -> 0xFFFFFFFC
  - 0xFE000CE3/010 -> 0xFFFFFFF8
  - 0x123450B7/011 -> 0x12345000
  - 0x0010006F/100 -> 0x00000800
  - Expect one result per cycle, with no gaps.
- **Stall:** `out_ready`=0 for 5 cycles with `in_valid`=1.
  - Output holds the first beat.
  - With skid: `in_ready` drops after the second accept. Without skid: `in_ready`=0 while stalled.
  - Releasing `out_ready` delivers the beats in order with no loss or duplication.
- **Flush:** assert `flush` on the same cycle as an accept while a beat is held -> next cycle `out_valid`=0, and neither beat ever appears.
- **Reserved select:** 3 beats with `in_sel`=111 -> `out_imm`=0, `out_err`=1, `err_cnt`=3. With `CNT_W`=2, 5 such beats -> `err_cnt`=3 (saturated).
- **XLEN=64:** `in_instr`=0x800000B7/011 -> `out_imm`=0xFFFFFFFF80000000. `in_instr`=0x03F01093/101 -> `out_imm`=0x3F. Then assert `rst_n` low mid-stall -> `out_valid`=0 immediately.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV32I/RV64I immediate generator with valid/ready output stage
//
// Optional feature macro: IMM_GEN_SKID_EN (adds a one-entry skid buffer; in_ready becomes registered)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_instr, in_sel, in_tag carry the beat
//   flush                 synchronous kill of every held beat and of same-cycle input
//   out_valid/out_ready   output handshake; out_imm, out_tag, out_err carry the beat
//   err_cnt               saturating count of accepted beats with reserved select 111
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic [XLEN-1:0] new_imm;
    logic            new_err;
    logic            accept;
    logic            retire;

    // Opcode bits never feed any immediate.
    logic unused_opcode;
    assign unused_opcode = ^in_instr[6:0];

    // Size casts of signed operands give the sign extension to XLEN.
    always_comb begin
        new_imm = '0;
        case (in_sel)
            3'b000:  new_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            3'b001:  new_imm = XLEN'($signed(in_instr[31:20]));
            3'b010:  new_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                              in_instr[11:8], 1'b0}));
            3'b011:  new_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            3'b100:  new_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                              in_instr[30:21], 1'b0}));
            3'b101:  new_imm = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
            3'b110:  new_imm = XLEN'(in_instr[19:15]);
            default: new_imm = '0;
        endcase
    end

    assign new_err = (in_sel == 3'b111);
    assign retire  = out_valid && out_ready;

`ifdef IMM_GEN_SKID_EN
    logic             skid_full;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_err;

    assign in_ready = !skid_full;
    assign accept   = in_valid && in_ready && !flush;

    // The skid entry is always older than any new beat, so it has first claim
    // on a free output register; accept cannot coincide with a full skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
            skid_full <= 1'b0;
            skid_imm  <= '0;
            skid_tag  <= '0;
            skid_err  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (!out_valid || retire) begin
            if (skid_full) begin
                out_valid <= 1'b1;
                out_imm   <= skid_imm;
                out_tag   <= skid_tag;
                out_err   <= skid_err;
                skid_full <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_imm   <= new_imm;
                out_tag   <= in_tag;
                out_err   <= new_err;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_full <= 1'b1;
            skid_imm  <= new_imm;
            skid_tag  <= in_tag;
            skid_err  <= new_err;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_imm   <= new_imm;
            out_tag   <= in_tag;
            out_err   <= new_err;
        end else if (retire) begin
            out_valid <= 1'b0;
        end
    end
`endif

    // accept already excludes flushed beats, so they never reach the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (accept && new_err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64/CNT_W=2 instances)
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, flush, out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_sel;
    logic [7:0]  in_tag;

    logic        in_ready0, out_valid0, out_err0;
    logic [31:0] out_imm0;
    logic [7:0]  out_tag0;
    logic [15:0] err_cnt0;

    logic        in_ready1, out_valid1, out_err1;
    logic [63:0] out_imm1;
    logic [7:0]  out_tag1;
    logic [1:0]  err_cnt1;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_imm(out_imm0),
        .out_tag(out_tag0), .out_err(out_err0), .err_cnt(err_cnt0)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_imm(out_imm1),
        .out_tag(out_tag1), .out_err(out_err1), .err_cnt(err_cnt1)
    );

`ifdef IMM_GEN_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        err;
    } beat_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [7:0]  tag;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        err;
    } vec_t;

    beat_t fifo [2][2];
    int    n;
    int    ecnt [2];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input longint raw, input int w);
        longint half;
        half = longint'(1) << (w - 1);
        return (raw >= half) ? raw - 2 * half : raw;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s, input int xlen);
        longint v;
        case (s)
            3'd0: v = sx(longint'({i[31:25], i[11:7]}), 12);
            3'd1: v = sx(longint'(i[31:20]), 12);
            3'd2: v = sx(longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
            3'd3: v = sx(longint'({i[31:12], 12'b0}), 32);
            3'd4: v = sx(longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
            3'd5: v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
            3'd6: v = longint'(i[19:15]);
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    function automatic logic model_rdy();
        return (CAP == 2) ? (n < 2) : (n == 0 || out_ready);
    endfunction

    task automatic model_edge();
        logic rdy;
        rdy = model_rdy();
        if (flush) begin
            n = 0;
        end else begin
            if (n > 0 && out_ready) begin
                for (int d = 0; d < 2; d++) fifo[d][0] = fifo[d][1];
                n--;
            end
            if (in_valid && rdy) begin
                for (int d = 0; d < 2; d++)
                    fifo[d][n] = '{imm: ref_imm(in_instr, in_sel, d == 1 ? 64 : 32),
                                   tag: in_tag, err: (in_sel == 3'd7)};
                n++;
                if (in_sel == 3'd7) begin
                    if (ecnt[0] < 65535) ecnt[0]++;
                    if (ecnt[1] < 3) ecnt[1]++;
                end
            end
        end
    endtask

    task automatic check_outs();
        chk("out_valid0", out_valid0, n > 0);
        chk("out_valid1", out_valid1, n > 0);
        if (n > 0) begin
            chk("out_imm0", out_imm0, fifo[0][0].imm[31:0]);
            chk("out_tag0", out_tag0, fifo[0][0].tag);
            chk("out_err0", out_err0, fifo[0][0].err);
            chk("out_imm1", out_imm1, fifo[1][0].imm);
            chk("out_tag1", out_tag1, fifo[1][0].tag);
            chk("out_err1", out_err1, fifo[1][0].err);
        end
        chk("err_cnt0", err_cnt0, ecnt[0]);
        chk("err_cnt1", err_cnt1, ecnt[1]);
    endtask

    // Called just after a rising edge; drives inputs, checks in_ready mid-cycle,
    // then advances the model on the edge and checks the registered outputs.
    task automatic cycle(input logic v, input logic [31:0] instr, input logic [2:0] sel,
                         input logic [7:0] tag, input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_sel    = sel;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        chk("in_ready0", in_ready0, model_rdy());
        chk("in_ready1", in_ready1, model_rdy());
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        n = 0;
        ecnt[0] = 0;
        ecnt[1] = 0;
        #1;
        chk("rst_valid0", out_valid0, 0);
        chk("rst_imm0", out_imm0, 0);
        chk("rst_tag0", out_tag0, 0);
        chk("rst_err0", out_err0, 0);
        chk("rst_cnt0", err_cnt0, 0);
        chk("rst_valid1", out_valid1, 0);
        chk("rst_imm1", out_imm1, 0);
        chk("rst_cnt1", err_cnt1, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready0", in_ready0, 1);
        chk("rst_in_ready1", in_ready1, 1);
    endtask

    vec_t       tbl [9];
    logic [7:0] got [$];
    int         cnt_before;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_sel = '0; in_tag = '0;

        tbl[0] = '{32'hFFF00093, 3'b001, 8'h5A, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        tbl[1] = '{32'hFE20AE23, 3'b000, 8'h11, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        tbl[2] = '{32'hFE000CE3, 3'b010, 8'h12, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
        tbl[3] = '{32'h123450B7, 3'b011, 8'h13, 32'h12345000, 64'h0000000012345000, 1'b0};
        tbl[4] = '{32'h0010006F, 3'b100, 8'h14, 32'h00000800, 64'h0000000000000800, 1'b0};
        tbl[5] = '{32'h800000B7, 3'b011, 8'h15, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        tbl[6] = '{32'h03F01093, 3'b101, 8'h16, 32'h0000001F, 64'h000000000000003F, 1'b0};
        tbl[7] = '{32'h000F8073, 3'b110, 8'h17, 32'h0000001F, 64'h000000000000001F, 1'b0};
        tbl[8] = '{32'h12345678, 3'b111, 8'h18, 32'h00000000, 64'h0000000000000000, 1'b1};

        do_reset();
        @(posedge clk); #1;

        // Back-to-back table beats: each must be on the output the cycle after issue.
        for (int k = 0; k < 9; k++) begin
            cycle(1'b1, tbl[k].instr, tbl[k].sel, tbl[k].tag, 1'b1, 1'b0);
            chk("tbl_valid", out_valid0, 1);
            chk("tbl_imm32", out_imm0, tbl[k].e32);
            chk("tbl_imm64", out_imm1, tbl[k].e64);
            chk("tbl_tag", out_tag0, tbl[k].tag);
            chk("tbl_err", out_err0, tbl[k].err);
        end
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
        chk("tbl_err_cnt", err_cnt0, 1);

        // Reserved select counting and 2-bit saturation.
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b1, $urandom, 3'b111, 8'h30 + 8'(k), 1'b1, 1'b0);
        chk("rsv_cnt0_3", err_cnt0, 3);
        chk("rsv_cnt1_3", err_cnt1, 3);
        chk("rsv_imm", out_imm0, 0);
        chk("rsv_err", out_err0, 1);
        for (int k = 0; k < 2; k++) cycle(1'b1, $urandom, 3'b111, 8'h33 + 8'(k), 1'b1, 1'b0);
        chk("rsv_cnt0_5", err_cnt0, 5);
        chk("rsv_cnt1_sat", err_cnt1, 3);
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Stall for five cycles with a continuous input stream.
        for (int k = 0; k < 5; k++) cycle(1'b1, $urandom, 3'b001, 8'h20 + 8'(k), 1'b0, 1'b0);
        chk("stall_hold_tag", out_tag0, 8'h20);
        chk("stall_in_ready", in_ready0, 0);
        got.delete();
        got.push_back(out_tag0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
            if (out_valid0) got.push_back(out_tag0);
        end
        chk("stall_count", got.size(), CAP);
        for (int k = 0; k < got.size(); k++) chk("stall_order", got[k], 8'h20 + 8'(k));

        // Flush with a held beat and a same-cycle reserved-select input.
        cycle(1'b1, 32'hFFF00093, 3'b001, 8'h40, 1'b0, 1'b0);
        cnt_before = err_cnt0;
        cycle(1'b1, 32'h0, 3'b111, 8'h41, 1'b0, 1'b1);
        chk("flush_valid0", out_valid0, 0);
        chk("flush_valid1", out_valid1, 0);
        chk("flush_cnt", err_cnt0, cnt_before);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
            chk("flush_gone", out_valid0, 0);
        end

        // Random traffic against the model.
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), 8'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // XLEN=64 specifics, then reset in the middle of a stall.
        cycle(1'b1, 32'h800000B7, 3'b011, 8'h77, 1'b0, 1'b0);
        chk("x64_u", out_imm1, 64'hFFFFFFFF80000000);
        cycle(1'b1, 32'h03F01093, 3'b101, 8'h78, 1'b0, 1'b0);
        chk("x64_stall_hold", out_tag1, 8'h77);
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
        if (CAP == 2) chk("x64_shamt", out_imm1, 64'h3F);
        cycle(1'b1, 32'h03F01093, 3'b101, 8'h79, 1'b0, 1'b0);
        chk("x64_shamt_b", out_imm1, 64'h3F);
        chk("x64_shamt32", out_imm0, 32'h1F);
        cycle(1'b1, 32'h0, 3'b001, 8'h7A, 1'b0, 1'b0);
        #1;
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
